// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// legal byte-enable codes and the lock timeout.
package dm_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_ARB   = 2'd0;
  localparam arb_state_t ST_LOCK0 = 2'd1;
  localparam arb_state_t ST_LOCK1 = 2'd2;

  localparam int LOCK_TIMEOUT = 16;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  // Only aligned word, half-word and byte lanes may reach the memory.
  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      BE_WORD, BE_HALF_HI, BE_HALF_LO,
      BE_BYTE3, BE_BYTE2, BE_BYTE1, BE_BYTE0: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-request round-robin picker; ptr names the requester that wins a tie.
module dm_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1
);

  // Tie goes to the requester selected by ptr; a lone request always wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = ~ptr;
      gnt1 = ptr;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the CPU MEM stage (m0) and the bridge port (m1) onto one
// data-memory port, with round-robin fairness and lockable ownership.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_be,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] dm_a,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [3:0]        dm_be,
  output logic              dm_memread,
  output logic              dm_memwrite,
  input  logic [DATA_W-1:0] dm_rd
);

  localparam logic [4:0] CNT_LAST = 5'(LOCK_TIMEOUT - 1);

  arb_state_t state_r, state_nxt_s;
  logic       ptr_r, ptr_nxt_s;
  logic [4:0] cnt_r, cnt_nxt_s;

  logic pick0_s, pick1_s;
  logic gnt0_s, gnt1_s;
  logic win_any_s, win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;
  logic [3:0] win_be_s;

  dm_rr_pick u_pick (
    .req0 (m0_req),
    .req1 (m1_req),
    .ptr  (ptr_r),
    .gnt0 (pick0_s),
    .gnt1 (pick1_s)
  );

  // Grant selection: picker in ARB, only the owner while locked, none in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_r)
        ST_ARB: begin
          gnt0_s = pick0_s;
          gnt1_s = pick1_s;
        end
        ST_LOCK0: gnt0_s = m0_req;
        ST_LOCK1: gnt1_s = m1_req;
        default: begin
          gnt0_s = pick0_s;
          gnt1_s = pick1_s;
        end
      endcase
    end
  end

  // Winner mux; the memory port is driven to zero when nobody is granted.
  always_comb begin
    win_any_s   = 1'b0;
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    win_be_s    = 4'b0000;
    if (gnt0_s) begin
      win_any_s   = 1'b1;
      win_we_s    = m0_we;
      win_addr_s  = m0_addr;
      win_wdata_s = m0_wdata;
      win_be_s    = m0_be;
    end else if (gnt1_s) begin
      win_any_s   = 1'b1;
      win_we_s    = m1_we;
      win_addr_s  = m1_addr;
      win_wdata_s = m1_wdata;
      win_be_s    = m1_be;
    end else begin
      win_any_s = 1'b0;
    end
  end

  assign m0_gnt      = gnt0_s;
  assign m1_gnt      = gnt1_s;
  assign dm_a        = win_addr_s;
  assign dm_wdata    = win_wdata_s;
  assign dm_be       = win_be_s;
  assign dm_memread  = win_any_s & ~win_we_s;
  assign dm_memwrite = win_any_s & win_we_s & be_legal(win_be_s);

  // Next state, fairness pointer and lock-idle counter.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_ARB: begin
        cnt_nxt_s = 5'd0;
        if (gnt0_s) begin
          ptr_nxt_s   = 1'b1;
          state_nxt_s = m0_lock ? ST_LOCK0 : ST_ARB;
        end else if (gnt1_s) begin
          ptr_nxt_s   = 1'b0;
          state_nxt_s = m1_lock ? ST_LOCK1 : ST_ARB;
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK0: begin
        if (gnt0_s) begin
          ptr_nxt_s   = 1'b1;
          cnt_nxt_s   = 5'd0;
          state_nxt_s = m0_lock ? ST_LOCK0 : ST_ARB;
        end else if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = 5'd0;
          state_nxt_s = ST_ARB;
        end else begin
          cnt_nxt_s = cnt_r + 5'd1;
        end
      end
      ST_LOCK1: begin
        if (gnt1_s) begin
          ptr_nxt_s   = 1'b0;
          cnt_nxt_s   = 5'd0;
          state_nxt_s = m1_lock ? ST_LOCK1 : ST_ARB;
        end else if (cnt_r == CNT_LAST) begin
          cnt_nxt_s   = 5'd0;
          state_nxt_s = ST_ARB;
        end else begin
          cnt_nxt_s = cnt_r + 5'd1;
        end
      end
      default: begin
        state_nxt_s = ST_ARB;
        cnt_nxt_s   = 5'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ARB;
      ptr_r   <= 1'b0;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Read return and error pulses; rdata only changes on a read granted to its owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt0_s & ~m0_we;
      m1_rvalid <= gnt1_s & ~m1_we;
      m0_err    <= gnt0_s & m0_we & ~be_legal(m0_be);
      m1_err    <= gnt1_s & m1_we & ~be_legal(m1_be);
      if (gnt0_s && !m0_we) begin
        m0_rdata <= dm_rd;
      end else begin
        m0_rdata <= m0_rdata;
      end
      if (gnt1_s && !m1_we) begin
        m1_rdata <= dm_rd;
      end else begin
        m1_rdata <= m1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed, table-driven bench for dm_arbiter with a byte-lane memory model.
module tb_dm_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        lock;
  } mreq_t;

  // g = {gnt0,gnt1,memread,memwrite}; r = {rvalid0,rvalid1,err0,err1} after the edge
  typedef struct {
    string       name;
    mreq_t       m0;
    mreq_t       m1;
    logic [3:0]  g;
    logic [11:0] da;
    logic [3:0]  db;
    logic [3:0]  r;
    logic [31:0] q0;
    logic [31:0] q1;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [11:0] m0_addr, m1_addr, dm_a;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, dm_wdata, dm_rd;
  logic [3:0] m0_be, m1_be, dm_be;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic dm_memread, dm_memwrite;

  logic [31:0] mem [0:4095];
  logic [31:0] bmask;
  vec_t vecs[$];
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_a(dm_a), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_memread(dm_memread),
    .dm_memwrite(dm_memwrite), .dm_rd(dm_rd)
  );

  assign dm_rd = mem[dm_a];
  assign bmask = {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};

  always @(posedge clk) begin
    if (dm_memwrite) mem[dm_a] <= (mem[dm_a] & ~bmask) | (dm_wdata & bmask);
  end

  function automatic mreq_t idle();
    mreq_t m;
    m = '0;
    return m;
  endfunction

  function automatic mreq_t rd(input logic [11:0] a, input logic [3:0] be, input logic lk);
    mreq_t m;
    m = '0;
    m.req = 1'b1; m.addr = a; m.be = be; m.lock = lk;
    return m;
  endfunction

  function automatic mreq_t wr(input logic [11:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic lk);
    mreq_t m;
    m = '0;
    m.req = 1'b1; m.we = 1'b1; m.addr = a; m.wdata = d; m.be = be; m.lock = lk;
    return m;
  endfunction

  task automatic add(input string nm, input mreq_t a, input mreq_t b, input logic [3:0] g,
                     input logic [11:0] da, input logic [3:0] db, input logic [3:0] r,
                     input logic [31:0] q0, input logic [31:0] q1);
    vec_t v;
    v.name = nm; v.m0 = a; v.m1 = b; v.g = g; v.da = da; v.db = db;
    v.r = r; v.q0 = q0; v.q1 = q1;
    vecs.push_back(v);
  endtask

  task automatic drive(input mreq_t a, input mreq_t b);
    m0_req = a.req; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wdata;
    m0_be = a.be; m0_lock = a.lock;
    m1_req = b.req; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wdata;
    m1_be = b.be; m1_lock = b.lock;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'h12345678;
    mem[12'h020] = 32'hCAFEF00D;
    mem[12'h030] = 32'h0BADBEEF;
    mem[12'h040] = 32'h11112222;

    add("m0_rd_alone", rd(12'h010, 4'b1111, 1'b0), idle(), 4'b1010, 12'h010, 4'b1111, 4'b1000, 32'h12345678, 32'h0);
    add("idle", idle(), idle(), 4'b0000, 12'h000, 4'b0000, 4'b0000, 32'h12345678, 32'h0);
    add("m1_rd_alone", idle(), rd(12'h020, 4'b1111, 1'b0), 4'b0110, 12'h020, 4'b1111, 4'b0100, 32'h12345678, 32'hCAFEF00D);
    add("rr_1", rd(12'h040, 4'b1111, 1'b0), rd(12'h030, 4'b1111, 1'b0), 4'b1010, 12'h040, 4'b1111, 4'b1000, 32'h11112222, 32'hCAFEF00D);
    add("rr_2", rd(12'h040, 4'b1111, 1'b0), rd(12'h030, 4'b1111, 1'b0), 4'b0110, 12'h030, 4'b1111, 4'b0100, 32'h11112222, 32'h0BADBEEF);
    add("rr_3", rd(12'h040, 4'b1111, 1'b0), rd(12'h030, 4'b1111, 1'b0), 4'b1010, 12'h040, 4'b1111, 4'b1000, 32'h11112222, 32'h0BADBEEF);
    add("rr_4", rd(12'h040, 4'b1111, 1'b0), rd(12'h030, 4'b1111, 1'b0), 4'b0110, 12'h030, 4'b1111, 4'b0100, 32'h11112222, 32'h0BADBEEF);
    add("rr_5", rd(12'h040, 4'b1111, 1'b0), rd(12'h030, 4'b1111, 1'b0), 4'b1010, 12'h040, 4'b1111, 4'b1000, 32'h11112222, 32'h0BADBEEF);
    add("rr_6", rd(12'h040, 4'b1111, 1'b0), rd(12'h030, 4'b1111, 1'b0), 4'b0110, 12'h030, 4'b1111, 4'b0100, 32'h11112222, 32'h0BADBEEF);
    add("bad_be_wr", wr(12'h050, 32'hAABBCCDD, 4'b0101, 1'b0), idle(), 4'b1000, 12'h050, 4'b0101, 4'b0010, 32'h11112222, 32'h0BADBEEF);
    add("rd_bad_be", rd(12'h050, 4'b0101, 1'b0), idle(), 4'b1010, 12'h050, 4'b0101, 4'b1000, 32'h0, 32'h0BADBEEF);
    add("rd_before_wr", idle(), rd(12'h010, 4'b1111, 1'b0), 4'b0110, 12'h010, 4'b1111, 4'b0100, 32'h0, 32'h12345678);
    add("wr_after_rd", idle(), wr(12'h010, 32'hDEADBEEF, 4'b1111, 1'b0), 4'b0101, 12'h010, 4'b1111, 4'b0000, 32'h0, 32'h12345678);
    add("rd_new", rd(12'h010, 4'b1111, 1'b0), idle(), 4'b1010, 12'h010, 4'b1111, 4'b1000, 32'hDEADBEEF, 32'h12345678);
    add("half_wr", wr(12'h010, 32'h00005555, 4'b0011, 1'b0), idle(), 4'b1001, 12'h010, 4'b0011, 4'b0000, 32'hDEADBEEF, 32'h12345678);
    add("rd_half", idle(), rd(12'h010, 4'b1111, 1'b0), 4'b0110, 12'h010, 4'b1111, 4'b0100, 32'hDEADBEEF, 32'hDEAD5555);
    add("lock1_rd", idle(), rd(12'h020, 4'b1111, 1'b1), 4'b0110, 12'h020, 4'b1111, 4'b0100, 32'hDEADBEEF, 32'hCAFEF00D);
    add("lock1_block", rd(12'h030, 4'b1111, 1'b0), idle(), 4'b0000, 12'h000, 4'b0000, 4'b0000, 32'hDEADBEEF, 32'hCAFEF00D);
    add("lock1_both", rd(12'h030, 4'b1111, 1'b0), rd(12'h040, 4'b1111, 1'b1), 4'b0110, 12'h040, 4'b1111, 4'b0100, 32'hDEADBEEF, 32'h11112222);
    add("lock1_unlock", rd(12'h030, 4'b1111, 1'b0), wr(12'h020, 32'h0000BEEF, 4'b1111, 1'b0), 4'b0101, 12'h020, 4'b1111, 4'b0000, 32'hDEADBEEF, 32'h11112222);
    add("after_unlock", rd(12'h030, 4'b1111, 1'b0), idle(), 4'b1010, 12'h030, 4'b1111, 4'b1000, 32'h0BADBEEF, 32'h11112222);
    add("rd_locked_wr", idle(), rd(12'h020, 4'b1111, 1'b0), 4'b0110, 12'h020, 4'b1111, 4'b0100, 32'h0BADBEEF, 32'h0000BEEF);

    // Reset with both requesters active: nothing may be granted.
    reset = 1'b1;
    drive(rd(12'h010, 4'b1111, 1'b0), rd(12'h020, 4'b1111, 1'b0));
    @(negedge clk);
    #1;
    chk1("rst.gnt0", m0_gnt, 1'b0);
    chk1("rst.gnt1", m1_gnt, 1'b0);
    chk1("rst.memread", dm_memread, 1'b0);
    chk("rst.dm_a", 32'(dm_a), 32'h0);
    @(posedge clk);
    #1;
    chk1("rst.rvalid0", m0_rvalid, 1'b0);
    chk1("rst.rvalid1", m1_rvalid, 1'b0);
    chk1("rst.err0", m0_err, 1'b0);
    chk("rst.rdata0", m0_rdata, 32'h0);
    chk("rst.rdata1", m1_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(idle(), idle());

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] ew;
      @(negedge clk);
      drive(vecs[i].m0, vecs[i].m1);
      ew = vecs[i].g[3] ? vecs[i].m0.wdata : (vecs[i].g[2] ? vecs[i].m1.wdata : 32'h0);
      #1;
      chk1({vecs[i].name, ".gnt0"}, m0_gnt, vecs[i].g[3]);
      chk1({vecs[i].name, ".gnt1"}, m1_gnt, vecs[i].g[2]);
      chk1({vecs[i].name, ".memread"}, dm_memread, vecs[i].g[1]);
      chk1({vecs[i].name, ".memwrite"}, dm_memwrite, vecs[i].g[0]);
      chk({vecs[i].name, ".dm_a"}, 32'(dm_a), 32'(vecs[i].da));
      chk({vecs[i].name, ".dm_be"}, 32'(dm_be), 32'(vecs[i].db));
      chk({vecs[i].name, ".dm_wdata"}, dm_wdata, ew);
      @(posedge clk);
      #1;
      chk1({vecs[i].name, ".rvalid0"}, m0_rvalid, vecs[i].r[3]);
      chk1({vecs[i].name, ".rvalid1"}, m1_rvalid, vecs[i].r[2]);
      chk1({vecs[i].name, ".err0"}, m0_err, vecs[i].r[1]);
      chk1({vecs[i].name, ".err1"}, m1_err, vecs[i].r[0]);
      chk({vecs[i].name, ".rdata0"}, m0_rdata, vecs[i].q0);
      chk({vecs[i].name, ".rdata1"}, m1_rdata, vecs[i].q1);
    end

    // Lock timeout: m1 locks then goes idle; m0 waits 16 cycles, wins on the 17th.
    @(negedge clk);
    drive(idle(), rd(12'h030, 4'b1111, 1'b1));
    #1;
    chk1("to.lock_gnt1", m1_gnt, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drive(rd(12'h040, 4'b1111, 1'b0), idle());
      #1;
      chk1($sformatf("to.wait%0d.gnt0", k), m0_gnt, 1'b0);
    end
    @(negedge clk);
    #1;
    chk1("to.cycle17.gnt0", m0_gnt, 1'b1);
    @(posedge clk);
    #1;
    chk1("to.rvalid0", m0_rvalid, 1'b1);
    chk("to.rdata0", m0_rdata, 32'h11112222);
    chk("to.rdata1", m1_rdata, 32'h0BADBEEF);

    // Reset during a write grant while locked: write blocked, state back to ARB.
    @(negedge clk);
    drive(idle(), rd(12'h020, 4'b1111, 1'b1));
    #1;
    chk1("rw.lock_gnt1", m1_gnt, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive(wr(12'h030, 32'h55555555, 4'b1111, 1'b0), idle());
    #1;
    chk1("rw.gnt0", m0_gnt, 1'b0);
    chk1("rw.memwrite", dm_memwrite, 1'b0);
    @(posedge clk);
    #1;
    chk1("rw.rvalid0", m0_rvalid, 1'b0);
    chk1("rw.rvalid1", m1_rvalid, 1'b0);
    chk("rw.rdata0", m0_rdata, 32'h0);
    chk("rw.rdata1", m1_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(rd(12'h030, 4'b1111, 1'b0), rd(12'h040, 4'b1111, 1'b0));
    #1;
    chk1("rw.post_gnt0", m0_gnt, 1'b1);
    chk1("rw.post_gnt1", m1_gnt, 1'b0);
    @(posedge clk);
    #1;
    chk1("rw.post_rvalid0", m0_rvalid, 1'b1);
    chk("rw.mem_unchanged", m0_rdata, 32'h0BADBEEF);

    @(negedge clk);
    drive(idle(), idle());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
